// File: rtl/norm_shift_pipe.sv
// Two-stage floating-point normalizer: S1 captures the operand and its leading-zero
// count, S2 shifts left by min(lzc, exponent) and adjusts the exponent.
module norm_shift_pipe #(
   parameter int WIDTH = 48,
   parameter int EXP_W = 10,
   parameter int LZC_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_mant,
   input  logic [EXP_W-1:0] in_exp,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_mant,
   output logic [EXP_W-1:0] out_exp,
   output logic [LZC_W-1:0] out_lzc,
   output logic             out_zero,
   output logic             out_denorm
);

   localparam int L  = $clog2(WIDTH);
   localparam int P  = 1 << L;
   localparam int CW = (EXP_W > LZC_W) ? EXP_W : LZC_W;

   logic             s1_valid, s2_valid;
   logic [WIDTH-1:0] s1_mant;
   logic [EXP_W-1:0] s1_exp;
   logic [LZC_W-1:0] s1_lzc;
   logic             s1_load, s2_load;

   // Mantissa is left-aligned in a power-of-two vector; zero padding below the LSB
   // never changes the count of a nonzero mantissa.
   logic [P-1:0] pad;
   logic [P-2:0] z_t;
   logic [L-1:0] c_t [P-1];
   logic [LZC_W-1:0] lzc_in;

   assign pad = P'(in_mant) << (P - WIDTH);

   // Node storage: level 1 (2-bit groups) at offset 0, level l at P - (P >> (l-1)),
   // root at P-2. Left child (higher bits) of a node is the odd index.
   always_comb begin
      z_t = '0;
      for (int i = 0; i < P-1; i++) c_t[i] = '0;
      for (int n = 0; n < P/2; n++) begin
         z_t[n] = ~(pad[2*n+1] | pad[2*n]);
         c_t[n] = {{(L-1){1'b0}}, ~pad[2*n+1]};
      end
      for (int l = 2; l <= L; l++) begin
         for (int n = 0; n < (P >> l); n++) begin
            z_t[P - (P >> (l-1)) + n] = z_t[P - (P >> (l-2)) + 2*n + 1]
                                      & z_t[P - (P >> (l-2)) + 2*n];
            c_t[P - (P >> (l-1)) + n] = z_t[P - (P >> (l-2)) + 2*n + 1]
               ? (c_t[P - (P >> (l-2)) + 2*n] | (L'(1) << (l-1)))
               : c_t[P - (P >> (l-2)) + 2*n + 1];
         end
      end
   end

   assign lzc_in = z_t[P-2] ? LZC_W'(WIDTH) : LZC_W'(c_t[P-2]);

   logic [CW-1:0] lzc_x, exp_x, shift;
   logic          s1_zero;

   assign lzc_x   = CW'(s1_lzc);
   assign exp_x   = CW'(s1_exp);
   assign shift   = (lzc_x < exp_x) ? lzc_x : exp_x;
   assign s1_zero = (s1_lzc == LZC_W'(WIDTH));

   assign s2_load   = s1_valid & (~s2_valid | out_ready);
   assign in_ready  = ~s1_valid | ~s2_valid | out_ready;
   assign s1_load   = in_valid & in_ready;
   assign out_valid = s2_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid   <= 1'b0;
         s2_valid   <= 1'b0;
         s1_mant    <= '0;
         s1_exp     <= '0;
         s1_lzc     <= '0;
         out_mant   <= '0;
         out_exp    <= '0;
         out_lzc    <= '0;
         out_zero   <= 1'b0;
         out_denorm <= 1'b0;
      end else begin
         if (s1_load) begin
            s1_mant <= in_mant;
            s1_exp  <= in_exp;
            s1_lzc  <= lzc_in;
         end
         if (s1_load)      s1_valid <= 1'b1;
         else if (s2_load) s1_valid <= 1'b0;

         if (s2_load) begin
            out_mant   <= s1_mant << shift;
            out_exp    <= s1_zero ? '0 : EXP_W'(exp_x - shift);
            out_lzc    <= s1_lzc;
            out_zero   <= s1_zero;
            out_denorm <= (lzc_x > exp_x) & ~s1_zero;
         end
         if (s2_load)        s2_valid <= 1'b1;
         else if (out_ready) s2_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_norm_shift_pipe.sv
// Bench for norm_shift_pipe: directed vector table, stall/reset sequences and a
// random sweep scored against a behavioural model.
module tb_norm_shift_pipe;
   localparam int WIDTH = 48;
   localparam int EXP_W = 10;
   localparam int LZC_W = 6;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_mant = '0;
   logic [EXP_W-1:0] in_exp = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_mant;
   logic [EXP_W-1:0] out_exp;
   logic [LZC_W-1:0] out_lzc;
   logic             out_zero, out_denorm;

   int checks = 0;
   int errors = 0;

   typedef logic [65:0] res_t;   // {mant, exp, lzc, zero, denorm}

   typedef struct {
      logic [47:0] m;
      logic [9:0]  e;
      logic [47:0] xm;
      logic [9:0]  xe;
      logic [5:0]  xl;
      logic        xz;
      logic        xd;
   } vec_t;

   vec_t vecs [12];
   res_t q[$];
   logic hold_pending = 1'b0;
   res_t held;

   norm_shift_pipe #(.WIDTH(WIDTH), .EXP_W(EXP_W), .LZC_W(LZC_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_mant(in_mant), .in_exp(in_exp),
      .out_valid(out_valid), .out_ready(out_ready), .out_mant(out_mant),
      .out_exp(out_exp), .out_lzc(out_lzc), .out_zero(out_zero), .out_denorm(out_denorm)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input res_t act, input res_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic res_t cur();
      return {out_mant, out_exp, out_lzc, out_zero, out_denorm};
   endfunction

   function automatic res_t model(input logic [47:0] m, input logic [9:0] e);
      int   lz, sh;
      logic z, d;
      logic [47:0] om;
      logic [9:0]  oe;
      lz = 48;
      for (int i = 0; i < 48; i++) if (m[i]) lz = 47 - i;
      sh = (lz < int'(e)) ? lz : int'(e);
      z  = (m == '0);
      om = m << sh;
      oe = z ? 10'd0 : 10'(int'(e) - sh);
      d  = (lz > int'(e)) && !z;
      return {om, oe, 6'(lz), z, d};
   endfunction

   // One clock cycle: drive at negedge, score handshakes before the next posedge.
   task automatic step(input logic iv, input logic [47:0] m, input logic [9:0] e,
                       input logic ordy);
      res_t r;
      @(negedge clk);
      in_valid = iv; in_mant = m; in_exp = e; out_ready = ordy;
      #1;
      if (hold_pending) begin
         chk("stall_hold", cur(), held);
         hold_pending = 1'b0;
      end
      if (in_valid && in_ready) q.push_back(model(m, e));
      if (out_valid && out_ready) begin
         if (q.size() == 0) chk("spurious_out", 66'd1, 66'd0);
         else begin
            r = q.pop_front();
            chk("scoreboard", cur(), r);
            if (!out_zero && !out_denorm) chk("msb_set", 66'(out_mant[47]), 66'd1);
         end
      end
      if (out_valid && !out_ready) begin
         hold_pending = 1'b1;
         held = cur();
      end
   endtask

   initial begin
      int idx, cyc;
      logic [47:0] rm;

      vecs[0]  = '{48'h0000_1000_0000, 10'd100,  48'h8000_0000_0000, 10'd81,   6'd19, 1'b0, 1'b0};
      vecs[1]  = '{48'h0000_0000_0001, 10'd10,   48'h0000_0000_0400, 10'd0,    6'd47, 1'b0, 1'b1};
      vecs[2]  = '{48'h0000_0000_0000, 10'd55,   48'h0000_0000_0000, 10'd0,    6'd48, 1'b1, 1'b0};
      vecs[3]  = '{48'h8000_0000_0000, 10'd5,    48'h8000_0000_0000, 10'd5,    6'd0,  1'b0, 1'b0};
      vecs[4]  = '{48'h0000_0000_00FF, 10'd40,   48'hFF00_0000_0000, 10'd0,    6'd40, 1'b0, 1'b0};
      vecs[5]  = '{48'h0000_0000_00FF, 10'd39,   48'h7F80_0000_0000, 10'd0,    6'd40, 1'b0, 1'b1};
      vecs[6]  = '{48'h0123_4567_89AB, 10'd3,    48'h091A_2B3C_4D58, 10'd0,    6'd7,  1'b0, 1'b1};
      vecs[7]  = '{48'h0123_4567_89AB, 10'd1023, 48'h91A2_B3C4_D580, 10'd1016, 6'd7,  1'b0, 1'b0};
      vecs[8]  = '{48'hFFFF_FFFF_FFFF, 10'd0,    48'hFFFF_FFFF_FFFF, 10'd0,    6'd0,  1'b0, 1'b0};
      vecs[9]  = '{48'h0000_0000_0001, 10'd0,    48'h0000_0000_0001, 10'd0,    6'd47, 1'b0, 1'b1};
      vecs[10] = '{48'h0000_0000_0000, 10'd0,    48'h0000_0000_0000, 10'd0,    6'd48, 1'b1, 1'b0};
      vecs[11] = '{48'h4000_0000_0000, 10'd1,    48'h8000_0000_0000, 10'd0,    6'd1,  1'b0, 1'b0};

      #1;
      chk("reset_out_valid", 66'(out_valid), 66'd0);
      chk("reset_in_ready",  66'(in_ready),  66'd1);
      chk("reset_outputs",   cur(),          66'd0);
      @(negedge clk);
      rst = 1'b0;

      // Directed table: one operand at a time, exact two-edge latency.
      foreach (vecs[i]) begin
         step(1'b1, vecs[i].m, vecs[i].e, 1'b1);
         chk("tbl_accept", 66'(in_ready), 66'd1);
         step(1'b0, '0, '0, 1'b1);
         chk("tbl_not_early", 66'(out_valid), 66'd0);
         step(1'b0, '0, '0, 1'b1);
         chk("tbl_valid", 66'(out_valid), 66'd1);
         chk($sformatf("tbl_vec%0d", i), cur(),
             {vecs[i].xm, vecs[i].xe, vecs[i].xl, vecs[i].xz, vecs[i].xd});
      end
      step(1'b0, '0, '0, 1'b1);

      // Back-to-back stream of 5 with out_ready low in cycles 2-4.
      idx = 0;
      for (cyc = 0; cyc < 30 && (idx < 5 || q.size() != 0); cyc++) begin
         step(idx < 5, vecs[idx % 12].m + 48'(idx), vecs[idx % 12].e,
              !(cyc >= 2 && cyc <= 4));
         if (cyc == 2) chk("stall_in_ready_low", 66'(in_ready), 66'd0);
         if (in_valid && in_ready) idx++;
      end
      chk("stream_all_accepted", 66'(idx), 66'd5);
      chk("stream_drained", 66'(q.size()), 66'd0);

      // Reset with two operands in flight.
      step(1'b1, 48'h0000_00F0_0000, 10'd200, 1'b0);
      step(1'b1, 48'h0000_0000_0F00, 10'd200, 1'b0);
      step(1'b0, '0, '0, 1'b0);
      chk("inflight_valid", 66'(out_valid), 66'd1);
      rst = 1'b1;
      #1;
      chk("rst_out_valid", 66'(out_valid), 66'd0);
      chk("rst_in_ready",  66'(in_ready),  66'd1);
      chk("rst_outputs",   cur(),          66'd0);
      q.delete();
      hold_pending = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      step(1'b1, vecs[0].m, vecs[0].e, 1'b1);
      chk("post_rst_accept", 66'(in_ready), 66'd1);
      for (int k = 0; k < 5; k++) step(1'b0, '0, '0, 1'b1);
      chk("post_rst_drained", 66'(q.size()), 66'd0);

      // Random sweep with random backpressure.
      for (int k = 0; k < 10000; k++) begin
         rm = {$urandom, $urandom} >> $urandom_range(0, 48);
         step($urandom_range(0, 3) != 0, rm,
              ($urandom_range(0, 1) != 0) ? 10'($urandom_range(0, 60)) : 10'($urandom),
              $urandom_range(0, 3) != 0);
      end
      for (int k = 0; k < 6; k++) step(1'b0, '0, '0, 1'b1);
      chk("sweep_drained", 66'(q.size()), 66'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
